// File: rtl/phy_rx_s2p_align_if.sv
// Lane-side bundle for the receive serial-to-parallel aligner: the serial
// bit in, and the recovered byte, its qualifier, the boundary strobe and
// the lock indication out.
interface phy_rx_s2p_align_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  // Serial source / byte consumer side
  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  byte_strobe,
    input  active
  );

  // Aligner side
  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output byte_strobe,
    output active
  );
endinterface

// File: rtl/phy_rx_s2p_align.sv
// Receive-side serial-to-parallel converter for one PHY lane. Bits arrive
// MSB first at clk32f; the aligner hunts for the COM symbol bit by bit,
// confirms ALIGN_COUNT consecutive COMs on a fixed byte phase, and then
// emits one byte per eight clocks, flagging non-COM bytes as valid.
module phy_rx_s2p_align #(
  parameter logic [7:0] COM         = 8'hBC,
  parameter int         ALIGN_COUNT = 4
) (
  input logic             clk32f,
  input logic             reset,
  phy_rx_s2p_align_if.slave rx
);

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    ALIGNING = 2'd1,
    ACTIVE   = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_CNT = 4'(ALIGN_COUNT);

  state_t     state;
  state_t     state_nx;
  logic [7:0] sr;
  logic [7:0] cand;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_nx;
  logic [3:0] com_cnt;
  logic [3:0] com_cnt_nx;
  logic [3:0] com_cnt_inc;
  logic [7:0] data_q;
  logic [7:0] data_nx;
  logic       valid_q;
  logic       valid_nx;
  logic       strobe_q;
  logic       strobe_nx;
  logic       boundary;
  logic       is_com;

  // The byte that ends with the bit being sampled on this edge; every
  // comparison and every output byte is taken from this window so that a
  // byte is recognised on the same edge that samples its LSB.
  assign cand        = {sr[6:0], rx.data_in};
  assign is_com      = (cand == COM);
  assign boundary    = (bit_cnt == 3'd7);
  assign com_cnt_inc = com_cnt + 4'd1;

  // Free-running shift register, independent of alignment state.
  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      sr <= 8'h00;
    end else begin
      sr <= cand;
    end
  end

  // State, byte-phase counter, COM counter and held output registers.
  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      state    <= SEARCH;
      bit_cnt  <= 3'd0;
      com_cnt  <= 4'd0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state    <= state_nx;
      bit_cnt  <= bit_cnt_nx;
      com_cnt  <= com_cnt_nx;
      data_q   <= data_nx;
      valid_q  <= valid_nx;
      strobe_q <= strobe_nx;
    end
  end

  // Alignment FSM: sliding search, phase-locked confirmation, then byte
  // delivery. Once locked, only reset can drop the lane out of ACTIVE, so a
  // COM pattern straddling two bytes never disturbs the byte phase.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    com_cnt_nx = com_cnt;
    data_nx    = data_q;
    valid_nx   = valid_q;
    strobe_nx  = 1'b0;

    case (state)
      SEARCH: begin
        bit_cnt_nx = 3'd0;
        com_cnt_nx = 4'd0;
        if (is_com) begin
          com_cnt_nx = 4'd1;
          state_nx   = ALIGNING;
        end
      end

      ALIGNING: begin
        bit_cnt_nx = bit_cnt + 3'd1;
        if (boundary) begin
          if (is_com) begin
            com_cnt_nx = com_cnt_inc;
            if (com_cnt_inc == LOCK_CNT) begin
              state_nx = ACTIVE;
            end
          end else begin
            state_nx   = SEARCH;
            com_cnt_nx = 4'd0;
            bit_cnt_nx = 3'd0;
          end
        end
      end

      ACTIVE: begin
        bit_cnt_nx = bit_cnt + 3'd1;
        if (boundary) begin
          data_nx   = cand;
          valid_nx  = !is_com;
          strobe_nx = 1'b1;
        end
      end

      default: begin
        state_nx   = SEARCH;
        bit_cnt_nx = 3'd0;
        com_cnt_nx = 4'd0;
      end
    endcase
  end

  assign rx.data_out    = data_q;
  assign rx.valid_out   = valid_q;
  assign rx.byte_strobe = strobe_q;
  assign rx.active      = (state == ACTIVE);

endmodule

// File: tb/tb_phy_rx_s2p_align.sv
// Scoreboard bench for phy_rx_s2p_align: the stimulus thread shifts bytes
// in MSB first and queues the byte each ACTIVE boundary should deliver; a
// monitor on the falling edge pops and compares on every byte_strobe and
// checks that outputs are held in between.
module tb_phy_rx_s2p_align;

  logic clk32f = 1'b0;
  logic reset  = 1'b0;

  phy_rx_s2p_align_if bus ();

  phy_rx_s2p_align #(
    .COM         (8'hBC),
    .ALIGN_COUNT (4)
  ) dut (
    .clk32f (clk32f),
    .reset  (reset),
    .rx     (bus.slave)
  );

  typedef struct {
    logic [7:0] data;
    logic       valid;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  int         tests_run = 0;
  int         fails     = 0;
  int         cyc       = 0;
  logic [7:0] hold_data;
  logic       hold_valid;

  // Bit clock
  always #5 clk32f = ~clk32f;

  // Rising-edge counter used to check the byte phase of each strobe
  always @(posedge clk32f) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Shift one bit in; returns just after the edge that sampled it
  task automatic send_bit(input logic b);
    bus.data_in = b;
    @(posedge clk32f);
    #1;
  endtask

  // Shift one byte in MSB first, queueing the byte expected on its boundary
  task automatic apply_stimulus(input logic [7:0] b, input bit expect_out);
    for (int i = 7; i >= 0; i--) begin
      bus.data_in = b[i];
      if (i == 0 && expect_out)
        exp_q.push_back(exp_t'{data: b, valid: (b != 8'hBC), due: cyc + 1});
      @(posedge clk32f);
      #1;
    end
  endtask

  // Monitor: compare queued bytes on each strobe, check holds otherwise
  always @(negedge clk32f) begin : monitor
    exp_t e;
    if (!reset) begin
      hold_data  = 8'h00;
      hold_valid = 1'b0;
      check_output("rst_data",   bus.data_out,    8'h00);
      check_output("rst_valid",  bus.valid_out,   1'b0);
      check_output("rst_strobe", bus.byte_strobe, 1'b0);
      check_output("rst_active", bus.active,      1'b0);
    end else if (bus.byte_strobe) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_strobe", bus.byte_strobe, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check_output("byte_data",    bus.data_out,  e.data);
        check_output("byte_valid",   bus.valid_out, e.valid);
        check_output("strobe_phase", cyc,           e.due);
        hold_data  = e.data;
        hold_valid = e.valid;
      end
    end else begin
      if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        check_output("missing_strobe", bus.byte_strobe, 1'b1);
        e = exp_q.pop_front();
        hold_data  = e.data;
        hold_valid = e.valid;
      end
      check_output("hold_data",  bus.data_out,  hold_data);
      check_output("hold_valid", bus.valid_out, hold_valid);
    end
  end

  initial begin
    bus.data_in = 1'b0;
    reset       = 1'b0;
    repeat (3) @(posedge clk32f);
    #1;
    check_output("reset_active", bus.active,   1'b0);
    check_output("reset_data",   bus.data_out, 8'h00);
    reset = 1'b1;

    // Garbage bits, then four COMs; lock on the LSB of the fourth
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(8'hBC, 1'b0);
      check_output("prelock_active", bus.active, 1'b0);
    end
    apply_stimulus(8'hBC, 1'b0);
    check_output("lock_active", bus.active, 1'b1);

    // Data bytes after lock
    apply_stimulus(8'hFF, 1'b1);
    apply_stimulus(8'hEE, 1'b1);
    apply_stimulus(8'hDD, 1'b1);
    apply_stimulus(8'hCC, 1'b1);

    // Idle COM then data
    apply_stimulus(8'hBC, 1'b1);
    apply_stimulus(8'h77, 1'b1);

    // COM straddling a boundary must not move the byte phase
    apply_stimulus(8'h0B, 1'b1);
    apply_stimulus(8'hC0, 1'b1);
    apply_stimulus(8'h3C, 1'b1);
    check_output("straddle_active", bus.active, 1'b1);

    // Asynchronous reset in the middle of a byte
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_output("async_data",   bus.data_out,    8'h00);
    check_output("async_valid",  bus.valid_out,   1'b0);
    check_output("async_strobe", bus.byte_strobe, 1'b0);
    check_output("async_active", bus.active,      1'b0);
    bus.data_in = 1'b0;
    repeat (2) @(posedge clk32f);
    #1;
    reset = 1'b1;

    // Re-alignment from SEARCH with a broken COM run
    apply_stimulus(8'hBC, 1'b0);
    check_output("realign1_active", bus.active, 1'b0);
    apply_stimulus(8'hBC, 1'b0);
    check_output("realign2_active", bus.active, 1'b0);
    apply_stimulus(8'h55, 1'b0);
    check_output("break_active", bus.active, 1'b0);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(8'hBC, 1'b0);
      check_output("fresh_com_active", bus.active, 1'b0);
    end
    apply_stimulus(8'hBC, 1'b0);
    check_output("relock_active", bus.active, 1'b1);
    apply_stimulus(8'hA5, 1'b1);
    apply_stimulus(8'hBC, 1'b1);

    repeat (3) @(negedge clk32f);
    check_output("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
